// File: rtl/mod7_seq_checker.sv
// ============================================================================
// Module      : mod7_seq_checker
// Description : Lock/error monitor for the mod-7 (0..6) state generator bus.
//               Optional sticky illegal-code flag: MOD7_CHK_ILLEGAL_STICKY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod7_seq_checker #(
  parameter int LOCK_COUNT = 3,
  parameter int LOSS_COUNT = 2,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [2:0]           in_state,
  output logic                 locked,
  output logic                 err_pulse,
  output logic                 wrap_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [2:0]           expected,
  output logic                 illegal_seen
);

  localparam int GR_W = $clog2(LOCK_COUNT + 1);
  localparam int BR_W = $clog2(LOSS_COUNT + 1);
  localparam logic [GR_W-1:0] C_LOCK_M1 = GR_W'(LOCK_COUNT - 1);
  localparam logic [BR_W-1:0] C_LOSS_M1 = BR_W'(LOSS_COUNT - 1);

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Code 7 is a legal predecessor of 0, mirroring the generator's 111->000 recovery.
  function automatic logic [2:0] succ(input logic [2:0] x);
    return (x >= 3'd6) ? 3'd0 : x + 3'd1;
  endfunction

  state_t                 r_state, w_state_nxt;
  logic [2:0]             r_prev, w_prev_nxt;
  logic                   r_have_prev, w_have_nxt;
  logic [GR_W-1:0]        r_good_run, w_good_nxt;
  logic [BR_W-1:0]        r_bad_run, w_bad_nxt;
  logic                   r_err_pulse, w_errp_nxt;
  logic                   r_wrap_pulse, w_wrapp_nxt;
  logic [ERR_CNT_W-1:0]   r_err_count, w_cnt_nxt;
  logic                   w_ok;

  assign w_ok = (in_state == succ(r_prev)) && (in_state != 3'd7);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= HUNT;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_prev_nxt  = r_prev;
    w_have_nxt  = r_have_prev;
    w_good_nxt  = r_good_run;
    w_bad_nxt   = r_bad_run;
    w_errp_nxt  = 1'b0;
    w_wrapp_nxt = 1'b0;
    w_cnt_nxt   = r_err_count;
    if (in_valid) begin
      w_prev_nxt = in_state;
      w_have_nxt = 1'b1;
      if (r_have_prev) begin
        case (r_state)
          HUNT: begin
            if (!w_ok) begin
              w_good_nxt = '0;
            end else if (r_good_run == C_LOCK_M1) begin
              w_state_nxt = LOCKED;
              w_good_nxt  = '0;
              w_bad_nxt   = '0;
            end else begin
              w_good_nxt = r_good_run + GR_W'(1);
            end
          end
          LOCKED: begin
            if (w_ok) begin
              w_bad_nxt   = '0;
              w_wrapp_nxt = (in_state == 3'd0);
            end else begin
              w_errp_nxt = 1'b1;
              if (r_err_count != {ERR_CNT_W{1'b1}})
                w_cnt_nxt = r_err_count + ERR_CNT_W'(1);
              if (r_bad_run == C_LOSS_M1) begin
                w_state_nxt = HUNT;
                w_good_nxt  = '0;
                w_bad_nxt   = '0;
              end else begin
                w_bad_nxt = r_bad_run + BR_W'(1);
              end
            end
          end
          default: w_state_nxt = HUNT;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev       <= '0;
      r_have_prev  <= 1'b0;
      r_good_run   <= '0;
      r_bad_run    <= '0;
      r_err_pulse  <= 1'b0;
      r_wrap_pulse <= 1'b0;
      r_err_count  <= '0;
    end else begin
      r_prev       <= w_prev_nxt;
      r_have_prev  <= w_have_nxt;
      r_good_run   <= w_good_nxt;
      r_bad_run    <= w_bad_nxt;
      r_err_pulse  <= w_errp_nxt;
      r_wrap_pulse <= w_wrapp_nxt;
      r_err_count  <= w_cnt_nxt;
    end
  end

  assign locked     = (r_state == LOCKED);
  assign err_pulse  = r_err_pulse;
  assign wrap_pulse = r_wrap_pulse;
  assign err_count  = r_err_count;
  assign expected   = r_have_prev ? succ(r_prev) : 3'd0;

`ifdef MOD7_CHK_ILLEGAL_STICKY_EN
  logic r_illegal;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                r_illegal <= 1'b0;
    else if (in_valid && in_state == 3'b111) r_illegal <= 1'b1;
  end

  assign illegal_seen = r_illegal;
`else
  assign illegal_seen = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mod7_seq_checker.sv
// ============================================================================
// Module      : tb_mod7_seq_checker
// Description : Scoreboard bench for mod7_seq_checker with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mod7_seq_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_state = 3'd0;
  logic       locked, err_pulse, wrap_pulse, illegal_seen;
  logic [7:0] err_count;
  logic [2:0] expected;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic       lk;
    logic       ep;
    logic       wp;
    logic [7:0] cnt;
    logic [2:0] ex;
    logic       il;
  } exp_t;

  exp_t q[$];
  exp_t e;
  logic tb_v;

  mod7_seq_checker #(.LOCK_COUNT(3), .LOSS_COUNT(2), .ERR_CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_state     (in_state),
    .locked       (locked),
    .err_pulse    (err_pulse),
    .wrap_pulse   (wrap_pulse),
    .err_count    (err_count),
    .expected     (expected),
    .illegal_seen (illegal_seen)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] succ(input logic [2:0] x);
    return (x >= 3'd6) ? 3'd0 : x + 3'd1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Marks cycles whose outputs reflect a valid sample.
  always @(posedge clk or negedge rst) begin
    if (!rst) tb_v <= 1'b0;
    else      tb_v <= in_valid;
  end

  always @(negedge clk) begin
    if (rst) begin
      if (tb_v) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_underflow: got empty queue expected an entry");
        end else begin
          e = q.pop_front();
          chk("locked",       32'(locked),       32'(e.lk));
          chk("err_pulse",    32'(err_pulse),    32'(e.ep));
          chk("wrap_pulse",   32'(wrap_pulse),   32'(e.wp));
          chk("err_count",    32'(err_count),    32'(e.cnt));
          chk("expected",     32'(expected),     32'(e.ex));
          chk("illegal_seen", 32'(illegal_seen), 32'(e.il));
        end
      end else begin
        chk("idle_err_pulse",  32'(err_pulse),  32'd0);
        chk("idle_wrap_pulse", 32'(wrap_pulse), 32'd0);
      end
    end
  end

  task automatic send(input logic [2:0] s, input logic lk, input logic ep, input logic wp,
                      input logic [7:0] cnt, input logic [2:0] ex, input logic il);
    exp_t t;
    @(negedge clk);
    in_valid = 1'b1;
    in_state = s;
    t.lk = lk; t.ep = ep; t.wp = wp; t.cnt = cnt; t.ex = ex;
`ifdef MOD7_CHK_ILLEGAL_STICKY_EN
    t.il = il;
`else
    t.il = 1'b0;
`endif
    q.push_back(t);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_locked",       32'(locked),       32'd0);
    chk("rst_err_pulse",    32'(err_pulse),    32'd0);
    chk("rst_wrap_pulse",   32'(wrap_pulse),   32'd0);
    chk("rst_err_count",    32'(err_count),    32'd0);
    chk("rst_expected",     32'(expected),     32'd0);
    chk("rst_illegal_seen", 32'(illegal_seen), 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [2:0] p, b, o;
    logic [7:0] n;

    do_reset();

    // Acquire lock on 0,1,2,3
    send(3'd0, 0, 0, 0, 8'd0, 3'd1, 0);
    send(3'd1, 0, 0, 0, 8'd0, 3'd2, 0);
    send(3'd2, 0, 0, 0, 8'd0, 3'd3, 0);
    send(3'd3, 1, 0, 0, 8'd0, 3'd4, 0);
    // 4 ok, 6 bad, 6->0 ok with wrap
    send(3'd4, 1, 0, 0, 8'd0, 3'd5, 0);
    send(3'd6, 1, 1, 0, 8'd1, 3'd0, 0);
    send(3'd0, 1, 0, 1, 8'd1, 3'd1, 0);
    // Two consecutive errors lose lock, then re-acquire
    send(3'd1, 1, 0, 0, 8'd1, 3'd2, 0);
    send(3'd4, 1, 1, 0, 8'd2, 3'd5, 0);
    send(3'd0, 0, 1, 0, 8'd3, 3'd1, 0);
    send(3'd1, 0, 0, 0, 8'd3, 3'd2, 0);
    send(3'd2, 0, 0, 0, 8'd3, 3'd3, 0);
    send(3'd3, 1, 0, 0, 8'd3, 3'd4, 0);
    // Illegal code 7 is an error; 7->0 is a correct wrap
    send(3'd7, 1, 1, 0, 8'd4, 3'd0, 1);
    send(3'd0, 1, 0, 1, 8'd4, 3'd1, 1);
    idle();
    idle();

    do_reset();

    // Gaps between samples are ignored
    send(3'd0, 0, 0, 0, 8'd0, 3'd1, 0);
    idle();
    send(3'd1, 0, 0, 0, 8'd0, 3'd2, 0);
    idle();
    send(3'd2, 0, 0, 0, 8'd0, 3'd3, 0);
    idle();
    send(3'd3, 1, 0, 0, 8'd0, 3'd4, 0);
    idle();

    // Alternate bad/good transitions while locked until the counter saturates
    p = 3'd3;
    for (int i = 0; i < 260; i++) begin
      b = succ(succ(p));
      n = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
      send(b, 1, 1, 0, n, succ(b), 0);
      o = succ(b);
      send(o, 1, 0, (o == 3'd0), n, succ(o), 0);
      p = o;
    end

    // Reset mid-run; the first sample afterwards is never checked
    send(succ(p), 1, 0, (succ(p) == 3'd0), 8'd255, succ(succ(p)), 0);
    do_reset();
    send(3'd5, 0, 0, 0, 8'd0, 3'd6, 0);
    send(3'd2, 0, 0, 0, 8'd0, 3'd3, 0);
    idle();
    idle();
    idle();

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
